mem_initiator: RTL and testbench

- Bus-master side of the 8-bit single-port data memory interface (addr, WR, memorywrite, memoryread, RD).
- Accepts byte read, byte write and multi-byte instruction-fetch requests from the control unit through a valid/ready handshake.
- Sequences the memory strobes and returns assembled read data with a one-cycle response pulse.
- Sits between the multi-cycle controller/datapath and the memory block.

---
 rtl/mem_initiator_if.sv | 36 +++
 rtl/mem_initiator.sv | 112 +++++++++++
 tb/tb_mem_initiator.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_initiator_if.sv
// Request/response handshake plus 8-bit single-port memory bus between the
// control unit, the memory initiator and the data memory.
interface mem_initiator_if #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int MAXLEN = 3
);
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_op;
    logic [AW-1:0]        req_addr;
    logic [DW-1:0]        req_wdata;
    logic [1:0]           req_len;
    logic                 rsp_valid;
    logic [MAXLEN*DW-1:0] rsp_data;
    logic                 rsp_err;
    logic [AW-1:0]        addr;
    logic [DW-1:0]        WR;
    logic                 memorywrite;
    logic                 memoryread;
    logic [DW-1:0]        RD;

    // The initiator itself.
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_len, RD,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               addr, WR, memorywrite, memoryread
    );

    // Controller plus memory environment around the initiator.
    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_len, RD,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               addr, WR, memorywrite, memoryread
    );
endinterface

// File: rtl/mem_initiator.sv
// Bus master for the 8-bit data memory: byte read, byte write and short
// instruction fetch bursts, answered with a one-cycle response pulse.
module mem_initiator #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int MAXLEN = 3
) (
    input  logic           clk,
    input  logic           rst,
    mem_initiator_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FETCH = 2'b10;

    logic [1:0]           state_q, state_d;
    logic [AW-1:0]        addr_q;
    logic [DW-1:0]        wdata_q;
    logic [1:0]           len_q;
    logic [1:0]           cnt_q;
    logic [MAXLEN*DW-1:0] byte_q;
    logic [MAXLEN*DW-1:0] rsp_data_q;
    logic                 rsp_err_q;

    logic                 accept;
    logic                 last_capture;
    logic [1:0]           len_eff;
    logic [MAXLEN*DW-1:0] capture_data;

    assign accept       = (state_q == S_IDLE) && bus.req_valid;
    assign last_capture = (state_q == S_READ) && (cnt_q == len_q - 2'd1);
    assign len_eff      = (bus.req_op != OP_FETCH) ? 2'd1 :
                          (bus.req_len == 2'd0)    ? 2'd1 : bus.req_len;

    // Byte buffer as it will look after this cycle's capture; slot k takes RD.
    for (genvar gi = 0; gi < MAXLEN; gi++) begin : g_slot
        assign capture_data[gi*DW +: DW] =
            (cnt_q == 2'(gi)) ? bus.RD : byte_q[gi*DW +: DW];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (bus.req_op)
                        OP_READ, OP_FETCH: state_d = S_READ;
                        OP_WRITE:          state_d = S_WRITE;
                        default:           state_d = S_RESP;
                    endcase
                end
            end
            S_READ:  if (last_capture) state_d = S_RESP;
            S_WRITE: state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            byte_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                len_q   <= len_eff;
                cnt_q   <= '0;
                byte_q  <= '0;
                // An illegal op goes straight to RESP, so its result is set now.
                if (bus.req_op == 2'b11) begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b1;
                end
            end
            if (state_q == S_READ) begin
                byte_q <= capture_data;
                addr_q <= addr_q + 1'b1;
                cnt_q  <= cnt_q + 2'd1;
                if (last_capture) begin
                    rsp_data_q <= capture_data;
                    rsp_err_q  <= 1'b0;
                end
            end
            if (state_q == S_WRITE) begin
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b0;
            end
        end
    end

    assign bus.req_ready   = (state_q == S_IDLE);
    assign bus.memoryread  = (state_q == S_READ);
    assign bus.memorywrite = (state_q == S_WRITE);
    assign bus.addr        = ((state_q == S_READ) || (state_q == S_WRITE)) ? addr_q : '0;
    assign bus.WR          = (state_q == S_WRITE) ? wdata_q : '0;
    assign bus.rsp_valid   = (state_q == S_RESP);
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
endmodule

// File: tb/tb_mem_initiator.sv
// Self-checking bench for mem_initiator: table of requests with a response
// scoreboard, plus hand-written held-valid and reset-abort sequences.
module tb_mem_initiator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_initiator_if #(.AW(8), .DW(8), .MAXLEN(3)) bus ();

    mem_initiator #(.AW(8), .DW(8), .MAXLEN(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Memory model: combinational read, write commits on the edge.
    logic [7:0] mem [256];
    logic       load_en = 1'b0;
    logic [7:0] load_addr = 8'h00;
    logic [7:0] load_data = 8'h00;
    assign bus.RD = mem[bus.addr];
    always @(posedge clk) begin
        if (load_en)              mem[load_addr] <= load_data;
        else if (bus.memorywrite) mem[bus.addr]  <= bus.WR;
    end

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [1:0]  len;
        logic [23:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_nrd;
        int          exp_nwr;
    } vec_t;

    typedef struct {
        logic [23:0] data;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] rd_log[$];
    logic [15:0] wr_log[$];
    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int n_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.req_valid && bus.req_ready) n_acc++;
        if (bus.memoryread || bus.memorywrite)
            check("strobe_mutex", {31'd0, bus.memoryread & bus.memorywrite}, 32'd0);
        if (bus.memoryread)  rd_log.push_back(bus.addr);
        if (bus.memorywrite) wr_log.push_back({bus.addr, bus.WR});
        if (bus.rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_data", {8'd0, bus.rsp_data}, {8'd0, e.data});
                check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
                check("latency", cyc - e.acc, e.lat);
                $display("rsp: data=%06h err=%0d latency=%0d", bus.rsp_data, bus.rsp_err, cyc - e.acc);
            end
        end
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        load_addr = a;
        load_data = d;
        load_en   = 1'b1;
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    // Present a request, wait for the accept edge, then scramble the fields.
    task automatic start_req(input logic [1:0] op, input logic [7:0] a, input logic [7:0] wd,
                             input logic [1:0] ln, output int acc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) check("ready_timeout", 32'd0, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_len   = ln;
        @(posedge clk);
        acc = cyc;
    endtask

    task automatic scramble_fields();
        bus.req_op    = 2'($urandom_range(0, 3));
        bus.req_addr  = 8'($urandom);
        bus.req_wdata = 8'($urandom);
        bus.req_len   = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        check("rsp_timeout", sb.size(), 32'd0);
        @(negedge clk);
    endtask

    vec_t vecs[10];

    initial begin
        int acc;
        int acc_before;
        logic [7:0] last_a;

        vecs[0] = '{2'b10, 8'd100, 8'h00, 2'd3, 24'h8D00A9, 1'b0, 4, 3, 0};
        vecs[1] = '{2'b01, 8'h10,  8'h5A, 2'd0, 24'h000000, 1'b0, 2, 0, 1};
        vecs[2] = '{2'b00, 8'h10,  8'h00, 2'd0, 24'h00005A, 1'b0, 2, 1, 0};
        vecs[3] = '{2'b10, 8'hFF,  8'h00, 2'd2, 24'h002211, 1'b0, 3, 2, 0};
        vecs[4] = '{2'b10, 8'h20,  8'h00, 2'd0, 24'h000077, 1'b0, 2, 1, 0};
        vecs[5] = '{2'b11, 8'h50,  8'hAB, 2'd2, 24'h000000, 1'b1, 1, 0, 0};
        vecs[6] = '{2'b00, 8'h40,  8'h00, 2'd0, 24'h00003C, 1'b0, 2, 1, 0};
        vecs[7] = '{2'b00, 8'h41,  8'h00, 2'd3, 24'h0000C3, 1'b0, 2, 1, 0};
        vecs[8] = '{2'b01, 8'hFF,  8'hEE, 2'd3, 24'h000000, 1'b0, 2, 0, 1};
        vecs[9] = '{2'b10, 8'hFE,  8'h00, 2'd3, 24'h22EE99, 1'b0, 4, 3, 0};

        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 8'h00;
        bus.req_len   = 2'd0;

        // Preload while the DUT is held in reset.
        for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);
        poke(8'd100, 8'hA9); poke(8'd101, 8'h00); poke(8'd102, 8'h8D);
        poke(8'hFF, 8'h11);  poke(8'h00, 8'h22);  poke(8'h20, 8'h77);
        poke(8'h40, 8'h3C);  poke(8'h41, 8'hC3);  poke(8'hFE, 8'h99);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'd0, bus.req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        check("reset_rsp_data", {8'd0, bus.rsp_data}, 32'd0);
        check("reset_addr", {24'd0, bus.addr}, 32'd0);
        check("reset_wr", {24'd0, bus.WR}, 32'd0);
        check("reset_strobes", {30'd0, bus.memoryread, bus.memorywrite}, 32'd0);
        rd_log.delete();
        wr_log.delete();

        for (int i = 0; i < 10; i++) begin
            start_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].len, acc);
            sb.push_back('{vecs[i].exp_data, vecs[i].exp_err, acc, vecs[i].exp_lat});
            #1 bus.req_valid = 1'b0;
            scramble_fields();
            wait_done();
            check("n_reads", rd_log.size(), vecs[i].exp_nrd);
            if (vecs[i].exp_nrd > 0) begin
                last_a = vecs[i].addr + 8'(vecs[i].exp_nrd - 1);
                check("first_rd_addr", {24'd0, rd_log[0]}, {24'd0, vecs[i].addr});
                check("last_rd_addr", {24'd0, rd_log[rd_log.size()-1]}, {24'd0, last_a});
            end
            check("n_writes", wr_log.size(), vecs[i].exp_nwr);
            if (vecs[i].exp_nwr > 0)
                check("write_bus", {16'd0, wr_log[0]}, {16'd0, vecs[i].addr, vecs[i].wdata});
            $display("vec %0d: op=%0d addr=%02h len=%0d reads=%0d writes=%0d",
                     i, vecs[i].op, vecs[i].addr, vecs[i].len, rd_log.size(), wr_log.size());
            rd_log.delete();
            wr_log.delete();
        end

        // req_valid held high through the busy cycles: exactly one accept.
        acc_before = n_acc;
        start_req(2'b10, 8'h20, 8'h00, 2'd0, acc);
        sb.push_back('{24'h000077, 1'b0, acc, 2});
        @(posedge clk);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        wait_done();
        check("held_valid_accepts", n_acc - acc_before, 32'd1);
        $display("held valid: accepts=%0d", n_acc - acc_before);
        rd_log.delete();

        // Reset during the second READ cycle of a 3-byte fetch.
        start_req(2'b10, 8'd100, 8'h00, 2'd3, acc);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'd0, bus.req_ready}, 32'd1);
        check("abort_strobes", {30'd0, bus.memoryread, bus.memorywrite}, 32'd0);
        check("abort_rsp_data", {8'd0, bus.rsp_data}, 32'd0);
        check("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        repeat (5) @(negedge clk);
        $display("fetch abort: reads before reset=%0d", rd_log.size());
        rd_log.delete();

        // Reset coinciding with the WRITE cycle still commits the byte.
        start_req(2'b01, 8'h60, 8'h33, 2'd0, acc);
        #1 bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_write_commit", {24'd0, mem[8'h60]}, 32'h33);
        check("abort_write_ready", {31'd0, bus.req_ready}, 32'd1);
        check("abort_write_strobe", {31'd0, bus.memorywrite}, 32'd0);
        repeat (4) @(negedge clk);
        $display("write abort: mem[60]=%02h writes=%0d", mem[8'h60], wr_log.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
